fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  PC/fetch stage feeding the decode Controlunit: holds the PC and fetches from instruction memory over a req/ack handshake.
//  Presents one instruction per execute slot, and computes next PC from the control outputs (PCSrc/Jump/JAL/JR).
//  Stalls on syscall until the service block acknowledges; halts permanently on the exit syscall.
// PARAMETERS
//  RESET_PC   32'h0040_0000  PC loaded on reset (text segment base)
//  EXIT_CODE  32'd10         $v0 value that makes syscall halt the core
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   reset: one clock; reset is synchronous and active-low
//  imem_req     out  1   fetch request; held until imem_ack
//  imem_addr    out  32  fetch address (= pc), stable while imem_req=1
//  imem_ack     in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  registered instruction to decode; held until next fetch completes
//  instr_valid  out  1   one-cycle execute slot; datapath gates RegWrite/MemWrite with it
//  pc           out  32  PC of instr
//  pc_plus4     out  32  pc+4 (JAL link value)
//  PCSrc,Jump,JAL,JR,syscall  in  1 each  decode outputs for instr
//  jr_target    in   32  rs register value for JR
//  v0           in   32  $v0 register value at syscall
//  sys_req      out  1   syscall service request; held until sys_ack
//  sys_code     out  32  latched $v0 of the pending syscall
//  sys_ack      in   1   service done
//  halted       out  1   exit syscall executed; sticky until reset
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, sys_req=0, sys_code=0, halted=0.
//   imem_req = (state==FETCH) & rst_n. Reset wins over every other event in the same cycle; pending acks are discarded.
//  FETCH: imem_req=1. On imem_ack: instr<=imem_rdata, ->EXEC. Same-cycle ack is legal; min 2 cycles/instr.
//  EXEC: instr_valid=1 for exactly this cycle; control inputs sampled here only.
//   syscall=1: sys_code<=v0; ->HALT if v0==EXIT_CODE (no sys_req), else ->SYS.
//   Otherwise pc<=next_pc, ->FETCH.
//  SYS: sys_req=1, sys_code stable. On sys_ack: sys_req=0, pc<=pc+4, ->FETCH.
//  HALT: halted=1, imem_req=0, sys_req=0; terminal until reset.
//  next_pc priority: JR > (Jump|JAL) > PCSrc > pc+4.
//   JR: {jr_target[31:2],2'b00} (misaligned bits cleared).
//   J/JAL: {pc_plus4[31:28], instr[25:0], 2'b00}.
//   branch: pc_plus4 + ({{14{instr[15]}},instr[15:0]} << 2).
//  PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
//  imem_ack is ignored outside FETCH; sys_ack is ignored outside SYS.
//  Control inputs are ignored outside EXEC.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - adds outputs instr_count[31:0] and stall_count[31:0], both reset to 0 and wrapping at 2^32.
//   - instr_count +1 per EXEC cycle.
//   - stall_count +1 per FETCH cycle without imem_ack and per SYS cycle.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Release rst_n with ack tied 1, rdata=addi -> imem_addr=0x00400000; instr_valid in cycle 2; next imem_addr=0x00400004.
//  2 BEQ at pc=0x00400008, imm=0xFFFF, PCSrc=1 -> next imem_addr=0x00400008. J 0x08100010 at 0x00400000 -> 0x00400040.
//  3 JR, jr_target=0x00400023, PCSrc=1 together -> next addr 0x00400020 (JR priority, low bits cleared).
//  4 syscall, v0=1, sys_ack after 3 cycles -> sys_req=1 and sys_code=1 held 3 cycles, then fetch pc+4.
//    syscall, v0=10 -> halted=1, no sys_req, imem_req stays 0.
//  5 imem_ack delayed 5 cycles -> imem_addr stable, instr_valid=0 throughout.
//    rst_n=0 mid-SYS -> sys_req=0 next cycle, pc=RESET_PC.
//  6 FETCH_PERF_CNT_EN: 3 instrs, each with 2 wait cycles -> instr_count=3, stall_count=6.
//    pc=0xFFFFFFFC sequential -> next addr 0x00000000.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle for fetch_sequencer: the instruction memory
// req/ack channel and the syscall service req/ack channel.
// The master modport is the sequencer; the slave modport is the
// memory / syscall service side.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        sys_req;
  logic [31:0] sys_code;
  logic        sys_ack;

  modport master (
    output imem_req, imem_addr, sys_req, sys_code,
    input  imem_ack, imem_rdata, sys_ack
  );

  modport slave (
    input  imem_req, imem_addr, sys_req, sys_code,
    output imem_ack, imem_rdata, sys_ack
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC / fetch stage in front of the decode control unit.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// offers it to the datapath for a single execute slot, then computes the
// next PC from the decode outputs (JR > Jump/JAL > PCSrc > pc+4).
// A syscall stalls the core until the service block acknowledges; the exit
// syscall halts it until the next reset.
// Optional feature macro: FETCH_PERF_CNT_EN adds instr_count/stall_count.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] EXIT_CODE = 32'd10
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  input  logic              PCSrc,
  input  logic              Jump,
  input  logic              JAL,
  input  logic              JR,
  input  logic              syscall,
  input  logic [31:0]       jr_target,
  input  logic [31:0]       v0,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    SYS   = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] sys_code_q, sys_code_d;
  logic [31:0] next_pc;
  logic [31:0] jr_aligned;
  logic [31:0] branch_offset;

  assign pc_plus4      = pc_q + 32'd4;
  assign jr_aligned    = jr_target & ~32'h0000_0003;
  assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Next PC for a non-syscall instruction; wraps modulo 2^32 naturally.
  always_comb begin
    next_pc = pc_plus4;
    if (JR) begin
      next_pc = jr_aligned;
    end else if (Jump || JAL) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (PCSrc) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

  // State transitions and the datapath registers they update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    sys_code_d = sys_code_q;
    unique case (state_q)
      FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (syscall) begin
          sys_code_d = v0;
          state_d    = (v0 == EXIT_CODE) ? HALT : SYS;
        end else begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      SYS: begin
        if (bus.sys_ack) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      sys_code_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      sys_code_q <= sys_code_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count_q;
  logic [31:0] stall_count_q;

  // Retired-slot and stall counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (state_q == EXEC) begin
        instr_count_q <= instr_count_q + 32'd1;
      end
      if ((state_q == FETCH && !bus.imem_ack) || state_q == SYS) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`endif

  assign bus.imem_req  = (state_q == FETCH) && rst_n;
  assign bus.imem_addr = pc_q;
  assign bus.sys_req   = (state_q == SYS);
  assign bus.sys_code  = sys_code_q;
  assign instr         = instr_q;
  assign instr_valid   = (state_q == EXEC);
  assign pc            = pc_q;
  assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. The bench plays instruction memory and
// the syscall service; expected fetch addresses and instruction words are
// queued when stimulus is driven and compared when the DUT presents them.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        pcSrc, jump, jal, jr, syscall;
  logic [31:0] jrTarget;
  logic [31:0] v0;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instrCount;
  logic [31:0] stallCount;
`endif

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] expAddrQ[$];
  logic [31:0] expInstrQ[$];
  logic [31:0] curPc;

  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pcPlus4),
    .PCSrc      (pcSrc),
    .Jump       (jump),
    .JAL        (jal),
    .JR         (jr),
    .syscall    (syscall),
    .jr_target  (jrTarget),
    .v0         (v0),
    .halted     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_count(instrCount),
    .stall_count(stallCount)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  // Serve one fetch: hold ack low for 'waits' cycles, then complete it.
  task automatic fetch(input logic [31:0] word, input int waits);
    logic [31:0] expAddr;
    if (expAddrQ.size() == 0) begin
      checkCount++;
      $display("[TB] FAIL fetch_queue: got empty scoreboard, required an expected address");
      expAddr = 32'hDEAD_BEEF;
    end else begin
      expAddr = expAddrQ.pop_front();
    end
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      checkCount++;
      if (bus.imem_req !== 1'b1) $display("[TB] FAIL imem_req: got %b required 1", bus.imem_req);
      else passCount++;
      checkCount++;
      if (bus.imem_addr !== expAddr) $display("[TB] FAIL imem_addr: got %h required %h", bus.imem_addr, expAddr);
      else passCount++;
      if (i < waits) begin
        checkCount++;
        if (instr_valid !== 1'b0) $display("[TB] FAIL valid_during_wait: got %b required 0", instr_valid);
        else passCount++;
      end else begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        expInstrQ.push_back(word);
      end
      @(posedge clk);
      #1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hBAD0_BAD0;
    end
    curPc = expAddr;
  endtask

  // Execute slot: check the presented instruction, then drive decode outputs.
  task automatic exec(input logic iJr, input logic iJump, input logic iJal,
                      input logic iPcSrc, input logic iSys,
                      input logic [31:0] iJrTarget, input logic [31:0] iV0);
    logic [31:0] expInstr;
    expInstr = (expInstrQ.size() != 0) ? expInstrQ.pop_front() : 32'hDEAD_BEEF;
    @(negedge clk);
    checkCount++;
    if (instr_valid !== 1'b1) $display("[TB] FAIL instr_valid: got %b required 1", instr_valid);
    else passCount++;
    checkCount++;
    if (instr !== expInstr) $display("[TB] FAIL instr: got %h required %h", instr, expInstr);
    else passCount++;
    checkCount++;
    if (pc !== curPc) $display("[TB] FAIL pc: got %h required %h", pc, curPc);
    else passCount++;
    checkCount++;
    if (pcPlus4 !== curPc + 32'd4) $display("[TB] FAIL pc_plus4: got %h required %h", pcPlus4, curPc + 32'd4);
    else passCount++;
    jr = iJr; jump = iJump; jal = iJal; pcSrc = iPcSrc; syscall = iSys;
    jrTarget = iJrTarget; v0 = iV0;
    @(posedge clk);
    #1;
    jr = 1'b0; jump = 1'b0; jal = 1'b0; pcSrc = 1'b0; syscall = 1'b0;
    jrTarget = 32'h0; v0 = 32'h0;
  endtask

  // Reset state with outputs checked while rst_n is still low.
  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkCount++;
    if (bus.imem_req !== 1'b0) $display("[TB] FAIL reset_imem_req: got %b required 0", bus.imem_req);
    else passCount++;
    checkCount++;
    if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b required 0", instr_valid);
    else passCount++;
    checkCount++;
    if (pc !== RESET_PC) $display("[TB] FAIL reset_pc: got %h required %h", pc, RESET_PC);
    else passCount++;
    checkCount++;
    if (instr !== 32'd0) $display("[TB] FAIL reset_instr: got %h required 0", instr);
    else passCount++;
    checkCount++;
    if (bus.sys_req !== 1'b0 || halted !== 1'b0 || bus.sys_code !== 32'd0)
      $display("[TB] FAIL reset_sys: got req=%b halted=%b code=%h required 0/0/0", bus.sys_req, halted, bus.sys_code);
    else passCount++;
    rst_n = 1'b1;
    expAddrQ.push_back(RESET_PC);
    @(posedge clk);
    #1;
  endtask

  // Two sequential addi instructions with ack returned immediately.
  task automatic test_sequential();
    fetch(32'h2008_0001, 0);
    expAddrQ.push_back(32'h0040_0004);
    exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'h2009_0002, 0);
    expAddrQ.push_back(32'h0040_0008);
    exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Backward branch by one word lands on itself.
  task automatic test_branch();
    fetch(32'h1000_FFFF, 0);
    expAddrQ.push_back(32'h0040_0008);
    exec(0, 0, 0, 1, 0, 32'h0, 32'h0);
  endtask

  // JR wins over a simultaneous branch and drops the misaligned bits.
  task automatic test_jr_priority();
    fetch(32'h0100_0008, 0);
    expAddrQ.push_back(32'h0040_0020);
    exec(1, 0, 0, 1, 0, 32'h0040_0023, 32'h0);
  endtask

  // Jump to a 26-bit target within the current 256 MB region.
  task automatic test_jump();
    fetch(32'h0810_0010, 0);
    expAddrQ.push_back(32'h0040_0040);
    exec(0, 1, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Slow memory: ack held off for five cycles.
  task automatic test_ack_delay();
    fetch(32'h2008_0003, 5);
    expAddrQ.push_back(curPc + 32'd4);
    exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

`ifdef FETCH_PERF_CNT_EN
  // Three instructions, two wait cycles each.
  task automatic test_perf_counters();
    logic [31:0] instrStart, stallStart;
    instrStart = instrCount;
    stallStart = stallCount;
    for (int k = 0; k < 3; k++) begin
      fetch(32'h2008_0010, 2);
      expAddrQ.push_back(curPc + 32'd4);
      exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
    end
    checkCount++;
    if (instrCount - instrStart !== 32'd3) $display("[TB] FAIL instr_count: got %0d required 3", instrCount - instrStart);
    else passCount++;
    checkCount++;
    if (stallCount - stallStart !== 32'd6) $display("[TB] FAIL stall_count: got %0d required 6", stallCount - stallStart);
    else passCount++;
  endtask
`endif

  // Non-exit syscall: request held for three cycles, then resume at pc+4.
  task automatic test_syscall();
    logic [31:0] sysPc;
    fetch(32'h0000_000C, 0);
    sysPc = curPc;
    exec(0, 0, 0, 0, 1, 32'h0, 32'd1);
    expAddrQ.push_back(sysPc + 32'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkCount++;
      if (bus.sys_req !== 1'b1 || bus.sys_code !== 32'd1)
        $display("[TB] FAIL sys_hold: got req=%b code=%h required 1/00000001", bus.sys_req, bus.sys_code);
      else passCount++;
      checkCount++;
      if (bus.imem_req !== 1'b0 || instr !== 32'h0000_000C)
        $display("[TB] FAIL sys_quiet: got imem_req=%b instr=%h required 0/0000000c", bus.imem_req, instr);
      else passCount++;
      bus.imem_ack   = (c != 2);
      bus.imem_rdata = 32'hFFFF_FFFF;
      bus.sys_ack    = (c == 2);
      @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      bus.sys_ack  = 1'b0;
    end
    test_after_sys();
  endtask

  // The instruction after a serviced syscall is fetched from pc+4.
  task automatic test_after_sys();
    fetch(32'h2008_0004, 0);
    expAddrQ.push_back(curPc + 32'd4);
    exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Reset during SYS beats a simultaneous sys_ack.
  task automatic test_reset_mid_sys();
    fetch(32'h0000_000C, 0);
    exec(0, 0, 0, 0, 1, 32'h0, 32'd5);
    @(negedge clk);
    checkCount++;
    if (bus.sys_req !== 1'b1 || bus.sys_code !== 32'd5)
      $display("[TB] FAIL sys_pending: got req=%b code=%h required 1/00000005", bus.sys_req, bus.sys_code);
    else passCount++;
    rst_n       = 1'b0;
    bus.sys_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.sys_ack = 1'b0;
    @(negedge clk);
    checkCount++;
    if (bus.sys_req !== 1'b0 || pc !== RESET_PC)
      $display("[TB] FAIL reset_mid_sys: got req=%b pc=%h required 0/%h", bus.sys_req, pc, RESET_PC);
    else passCount++;
    checkCount++;
    if (bus.imem_req !== 1'b0) $display("[TB] FAIL reset_mid_sys_req: got %b required 0", bus.imem_req);
    else passCount++;
    rst_n = 1'b1;
    expAddrQ.push_back(RESET_PC);
    @(posedge clk);
    #1;
  endtask

  // Sequential fetch from the top of the address space wraps to zero.
  task automatic test_pc_wrap();
    fetch(32'h0100_0008, 0);
    expAddrQ.push_back(32'hFFFF_FFFC);
    exec(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
    fetch(32'h2008_0005, 0);
    expAddrQ.push_back(32'h0000_0000);
    exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'h2008_0006, 0);
    expAddrQ.push_back(32'h0000_0004);
    exec(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Exit syscall: halt with no service request, memory acks ignored.
  task automatic test_halt();
    fetch(32'h0000_000C, 0);
    exec(0, 0, 0, 0, 1, 32'h0, 32'd10);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkCount++;
      if (halted !== 1'b1 || bus.sys_req !== 1'b0)
        $display("[TB] FAIL halt_state: got halted=%b sys_req=%b required 1/0", halted, bus.sys_req);
      else passCount++;
      checkCount++;
      if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0)
        $display("[TB] FAIL halt_quiet: got imem_req=%b valid=%b required 0/0", bus.imem_req, instr_valid);
      else passCount++;
      bus.imem_ack = 1'b1;
      bus.sys_ack  = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b0;
    bus.sys_ack  = 1'b0;
    checkCount++;
    if (bus.sys_code !== 32'd10) $display("[TB] FAIL halt_code: got %h required 0000000a", bus.sys_code);
    else passCount++;
  endtask

  // Scenario sequence.
  initial begin
    rst_n = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.sys_ack = 1'b0;
    pcSrc = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; syscall = 1'b0;
    jrTarget = 32'h0; v0 = 32'h0;
    curPc = RESET_PC;
    test_reset();
    test_sequential();
    test_branch();
    test_jr_priority();
    test_jump();
    test_ack_delay();
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    test_syscall();
    test_reset_mid_sys();
    test_pc_wrap();
    test_halt();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
